// File: rtl/fft_ram_writer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_pkg : shared FFT frame constants and the RAM writer state encoding.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fft_pkg;

  localparam int FFT_N  = 1024;
  localparam int SAMP_W = 14;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 2 * SAMP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_ram_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_ram_writer_if : FFT sink stream, RAM write port and detect handshake.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fft_ram_writer_if
  import fft_pkg::*;
#(
  parameter int SAMP_W = fft_pkg::SAMP_W,
  parameter int ADDR_W = fft_pkg::ADDR_W
) ();

  logic                  sink_valid;
  logic                  sink_sop;
  logic                  sink_eop;
  logic [SAMP_W-1:0]     sink_real;
  logic [SAMP_W-1:0]     sink_imag;
  logic                  sink_ready;
  logic                  wren;
  logic [ADDR_W-1:0]     wraddr;
  logic [2*SAMP_W-1:0]   wrdata;
  logic                  fftdone;
  logic                  detectdone;
  logic                  frame_err;

  // master: FFT source plus RAM consumer side; slave: the writer itself
  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, detectdone,
    input  sink_ready, wren, wraddr, wrdata, fftdone, frame_err
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, detectdone,
    output sink_ready, wren, wraddr, wrdata, fftdone, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/fft_ram_writer_bitrev.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bitrev : combinational bit reversal of a bin index over ADDR_W bits.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bitrev
  import fft_pkg::*;
#(
  parameter int ADDR_W = fft_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] bin_i,
  output logic [ADDR_W-1:0] addr_o
);

  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign addr_o[i] = bin_i[ADDR_W-1-i];
  end

endmodule
`default_nettype wire

// File: rtl/fft_ram_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_ram_writer : stores one FFT output frame into FFT_RAM, then hands    |
// | the RAM to freqdetect. FFT_RAM_WRITER_BITREV_EN selects bit-reversed     |
// | write addresses. Revision: 1.0                                           |
// +--------------------------------------------------------------------------+
module fft_ram_writer
  import fft_pkg::*;
#(
  parameter int FFT_N  = fft_pkg::FFT_N,
  parameter int SAMP_W = fft_pkg::SAMP_W,
  parameter int ADDR_W = fft_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  fft_ram_writer_if.slave   bus
);

  localparam int                DATA_W   = 2 * SAMP_W;
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_N - 1);

  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   bin;
  logic [ADDR_W-1:0]   addr;
  logic                accept;
  logic                wr_d, err_d, fftdone_d;
  logic                wren_q, frame_err_q, fftdone_q;
  logic [ADDR_W-1:0]   wraddr_q;
  logic [DATA_W-1:0]   wrdata_q;

  assign bus.sink_ready = (state_q != ST_DONE);
  assign accept         = bus.sink_valid & bus.sink_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin       = cnt_q;
    wr_d      = 1'b0;
    err_d     = 1'b0;
    fftdone_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.sink_sop) begin
          bin  = '0;
          wr_d = 1'b1;
        end
      end
      ST_FILL: begin
        if (accept) begin
          wr_d = 1'b1;
          if (bus.sink_sop) begin
            bin   = '0;
            err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // release only once fftdone has actually been seen high
        if (fftdone_q && bus.detectdone) begin
          state_d = ST_IDLE;
        end else begin
          fftdone_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_d) begin
      if (bus.sink_eop || (bin == LAST_BIN)) begin
        // a frame is good only when eop and the last bin coincide
        state_d = (bus.sink_eop && (bin == LAST_BIN)) ? ST_DONE : ST_IDLE;
        err_d   = err_d | ~(bus.sink_eop && (bin == LAST_BIN));
        cnt_d   = '0;
      end else begin
        state_d = ST_FILL;
        cnt_d   = bin + 1'b1;
      end
    end
  end

`ifdef FFT_RAM_WRITER_BITREV_EN
  bitrev #(.ADDR_W(ADDR_W)) u_bitrev (
    .bin_i  (bin),
    .addr_o (addr)
  );
`else
  assign addr = bin;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wrdata_q    <= '0;
      fftdone_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wren_q      <= wr_d;
      fftdone_q   <= fftdone_d;
      frame_err_q <= err_d;
      if (wr_d) begin
        wraddr_q <= addr;
        wrdata_q <= {bus.sink_real, bus.sink_imag};
      end
    end
  end

  assign bus.wren      = wren_q;
  assign bus.wraddr    = wraddr_q;
  assign bus.wrdata    = wrdata_q;
  assign bus.fftdone   = fftdone_q;
  assign bus.frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: doc/fft_ram_writer.md
FFT_RAM_WRITER -- requirements
Module: fft_ram_writer

Interface
REQ-001 Parameters (name, default, meaning): FFT_N, 1024, frame length in bins; SAMP_W, 14, real/imag sample width; ADDR_W, 10, RAM address width (log2 FFT_N).
REQ-002 clk  in  1  sole clock, all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 sink_valid  in  1  FFT output beat valid.
REQ-005 sink_sop  in  1  first beat of frame; sink_eop  in  1  last beat of frame.
REQ-006 sink_real, sink_imag  in  SAMP_W each  bin value, two's complement.
REQ-007 sink_ready  out  1  beat accepted when sink_valid and sink_ready are both high.
REQ-008 wren  out  1; wraddr  out  ADDR_W; wrdata  out  2*SAMP_W  write port to FFT_RAM.
REQ-009 fftdone  out  1  frame stored, RAM owned by freqdetect.
REQ-010 detectdone  in  1  freqdetect finished, RAM released.
REQ-011 frame_err  out  1  one-cycle pulse on malformed frame.

Function
REQ-012 FSM states: IDLE, FILL, DONE.
REQ-013 IDLE: sink_ready=1; accepted beat with sop -> FILL, written as bin 0; accepted beat without sop discarded.
REQ-014 FILL: sink_ready=1; each accepted beat writes bin = counter, counter increments by 1.
REQ-015 wrdata = {sink_real, sink_imag}, real in upper SAMP_W bits, no scaling.
REQ-016 wren/wraddr/wrdata registered: asserted exactly 1 cycle after acceptance, wren high for 1 cycle per beat.
REQ-017 Accepted eop at bin FFT_N-1 -> DONE; fftdone rises the cycle after that bin's wren cycle.
REQ-018 Accepted eop at bin < FFT_N-1 -> frame_err pulse, IDLE, no fftdone; bins already written stay in RAM.
REQ-019 Bin FFT_N-1 accepted without eop -> frame_err pulse, IDLE; counter never wraps past FFT_N-1.
REQ-020 sop accepted in FILL -> frame_err pulse, beat written as bin 0, counter restarts, stays FILL.
REQ-021 DONE: sink_ready=0, wren=0, fftdone held high until detectdone sampled high.
REQ-022 detectdone high in DONE -> fftdone low and IDLE next cycle; detectdone in IDLE/FILL ignored.
REQ-023 sink_valid low in FILL stalls counter; no timeout.

Reset
REQ-024 reset_n low asynchronously forces IDLE, counter=0, wren=0, wraddr=0, wrdata=0, fftdone=0, frame_err=0; sink_ready=1 after deassertion.
REQ-025 Reset mid-FILL or mid-DONE abandons frame; no fftdone, no frame_err.

Configuration
REQ-026 Macro FFT_RAM_WRITER_BITREV_EN defined: wraddr = bit-reverse of bin index over ADDR_W bits (matches freqdetect's reversed read).
REQ-027 Macro undefined: wraddr = bin index (natural order); all other behaviour identical.

Structure
REQ-028 Package fft_pkg holds FFT_N, SAMP_W, ADDR_W, DATA_W (=2*SAMP_W) constants and the writer state enum typedef.
REQ-029 One sub-module bitrev (parameter ADDR_W, combinational reversal), instantiated only under FFT_RAM_WRITER_BITREV_EN.

Verification
REQ-030 Full frame, bin k = {k, ~k} (14b), BITREV_EN defined -> bin 204 at wraddr 0x0CC, bin 1 at 0x200; fftdone high 1 cycle after last wren.
REQ-031 DONE held, sink_valid=1 for 50 cycles -> sink_ready=0, no wren; detectdone pulse -> fftdone low, IDLE, ready=1 next cycle.
REQ-032 eop at bin 500 -> frame_err single pulse, fftdone stays 0, next sop frame completes normally.
REQ-033 sop reissued at bin 300 -> frame_err pulse, next write at bin-0 address, frame completes after 1024 further beats.
REQ-034 Random sink_valid gaps (~30% duty) -> exactly 1024 wren pulses, addresses unique, data matches input order.
REQ-035 reset_n low at bin 600 -> outputs zero immediately (async), no fftdone; macro undefined run -> wraddr equals bin index.
